vec_chunk_sequencer: RTL and testbench
======================================

// Module: vec_chunk_sequencer
// PURPOSE
//  Sequences one multi-cycle vector instruction held in Execute over the LANES-wide vector ALU/memory datapath.
//  Each issued chunk carries a base element index and a lane mask.
//  StallSeq is ORed into the hazard unit's StallF/StallD/StallE terms, so the pipeline freezes while the chunks run.
//  DoneE pulses when the instruction may leave Execute.
// PARAMETERS
//  VLEN   16  max vector length in elements; must be a multiple of LANES
//  LANES   4  elements processed per chunk (ALU lanes / memory beats)
//  IDXW   $clog2(VLEN)  element index width (derived, do not override)
// PORTS
//  clk        in   1         system clock, all state on rising edge
//  reset      in   1         synchronous, active-high
//  StartE     in   1         Execute holds a vector op needing sequencing
//  VlE        in   IDXW+1    active vector length, 0..VLEN; values >VLEN clamp to VLEN
//  MemOpE     in   1         the op in Execute is a vector load/store (chunks need MemReadyM)
//  MemReadyM  in   1         memory accepts the current chunk this cycle
//  FlushE     in   1         flush of Execute from the hazard unit
//  ChunkValid out  1         a chunk is presented on ChunkBase/LaneMask
//  ChunkBase  out  IDXW      index of lane 0 of the current chunk
//  LaneMask   out  LANES     bit i = element ChunkBase+i < VL
//  ChunkLast  out  1         the current chunk is the final chunk
//  StallSeq   out  1         freeze F/D/E (to hazard unit)
//  DoneE      out  1         one-cycle pulse: op finished, Execute may advance
// BEHAVIOUR
//  Reset: state=IDLE, base=0, vl=0, memop=0. All outputs are 0.
//  States: IDLE, RUN, DONE.
//  IDLE
//   - StartE & !FlushE & VlE!=0: latch vl=min(VlE,VLEN) and memop=MemOpE; base<=0; go to RUN.
//   - StartE & !FlushE & VlE==0: go to DONE; no chunk is issued.
//   - StartE & FlushE: ignored; stay in IDLE.
//  RUN
//   - ChunkValid=1.
//   - Accept = ChunkValid & (!memop | MemReadyM).
//   - On accept: if ChunkLast go to DONE, else base<=base+LANES.
//   - With no accept, ChunkBase/LaneMask/ChunkLast hold stable (no wait limit).
//  DONE
//   - DoneE=1 and StallSeq=0, so the instruction leaves Execute at the end of this cycle.
//   - StartE is ignored (it is the same instruction).
//   - Go to IDLE.
//  StallSeq = (IDLE & StartE & !FlushE) | RUN. It is combinational, so the first cycle also stalls.
//  LaneMask[i] = (base+i < vl). ChunkLast = (base+LANES >= vl). Compare at IDXW+1 bits so base+LANES=VLEN does not wrap.
//  Latency with no memory back-pressure: one IDLE cycle, then ceil(vl/LANES) RUN cycles, then one DONE cycle.
//   - Stalled cycles = ceil(vl/LANES)+1.
//  FlushE in RUN: abort to IDLE next cycle. No DoneE; the aborted chunk is not accepted.
//  FlushE in DONE: still go to IDLE; DoneE is still pulsed (hazard unit owns the flush).
//  Reset mid-RUN: IDLE next cycle; all outputs 0; no DoneE.
//  MemReadyM is don't-care when memop=0 or the state is not RUN.
// TESTING
//  1. VlE=10, MemOpE=0, StartE held -> StallSeq high 4 cycles.
//     Chunks (base,mask) = (0,1111),(4,1111),(8,0011); ChunkLast only on the 3rd chunk; DoneE in cycle 5.
//  2. VlE=16, MemOpE=1, MemReadyM low 2 cycles on chunk base 4 -> base 4/mask 1111 held for 3 cycles.
//     4 chunks total, ending at base 12 with ChunkLast=1; DoneE exactly once.
//  3. VlE=0 -> no ChunkValid; StallSeq 1 cycle; DoneE the next cycle.
//     VlE=20 -> clamped: 4 full chunks, last mask 1111.
//  4. Start then FlushE in the 2nd RUN cycle -> IDLE; no DoneE; no further ChunkValid.
//     Reset in RUN -> all outputs 0 the next cycle.
//  5. StartE held high across DONE -> no restart.
//     A new StartE in the cycle after DONE starts a new sequence from base 0.

Source files
------------

// File: rtl/vec_chunk_sequencer.sv
// Steps one vector instruction held in Execute across the LANES-wide datapath,
// one chunk (base index + lane mask) per accepted cycle, freezing F/D/E meanwhile.
module vec_chunk_sequencer #(
    parameter int VLEN  = 16,
    parameter int LANES = 4,
    localparam int IDXW = $clog2(VLEN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StartE,
    input  logic [IDXW:0]    VlE,
    input  logic             MemOpE,
    input  logic             MemReadyM,
    input  logic             FlushE,
    output logic             ChunkValid,
    output logic [IDXW-1:0]  ChunkBase,
    output logic [LANES-1:0] LaneMask,
    output logic             ChunkLast,
    output logic             StallSeq,
    output logic             DoneE
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [IDXW:0]   VlMax     = (IDXW+1)'(VLEN);
    localparam logic [IDXW:0]   LanesWide = (IDXW+1)'(LANES);
    localparam logic [IDXW-1:0] LanesStep = IDXW'(LANES);

    state_t          stateReg;
    logic [IDXW-1:0] baseReg;
    logic [IDXW:0]   vlReg;
    logic            memopReg;

    logic            inRun;
    logic            accept;
    logic            lastChunk;
    logic [IDXW:0]   baseWide;
    logic [IDXW:0]   vlClamped;

    assign inRun     = (stateReg == RUN);
    // One extra bit so base+LANES reaching VLEN compares correctly instead of wrapping.
    assign baseWide  = {1'b0, baseReg};
    assign lastChunk = (baseWide + LanesWide) >= vlReg;
    assign accept    = inRun & (~memopReg | MemReadyM) & ~FlushE;
    assign vlClamped = (VlE > VlMax) ? VlMax : VlE;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign LaneMask[gi] = inRun & ((baseWide + (IDXW+1)'(gi)) < vlReg);
        end
    endgenerate

    assign ChunkValid = inRun;
    assign ChunkBase  = inRun ? baseReg : '0;
    assign ChunkLast  = inRun & lastChunk;
    assign DoneE      = (stateReg == DONE);
    // Combinational so the pipeline is already frozen in the cycle the op is first seen.
    assign StallSeq   = ((stateReg == IDLE) & StartE & ~FlushE) | inRun;

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg <= IDLE;
            baseReg  <= '0;
            vlReg    <= '0;
            memopReg <= 1'b0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (StartE && !FlushE) begin
                        if (VlE != '0) begin
                            vlReg    <= vlClamped;
                            memopReg <= MemOpE;
                            baseReg  <= '0;
                            stateReg <= RUN;
                        end else begin
                            stateReg <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (FlushE) begin
                        baseReg  <= '0;
                        stateReg <= IDLE;
                    end else if (accept) begin
                        if (lastChunk) begin
                            stateReg <= DONE;
                        end else begin
                            baseReg <= baseReg + LanesStep;
                        end
                    end
                end
                DONE: begin
                    // StartE here is still the finishing instruction, never a new one.
                    baseReg  <= '0;
                    stateReg <= IDLE;
                end
                default: stateReg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_chunk_sequencer.sv
// Directed bench for vec_chunk_sequencer: stimulus queues the expected chunk/done
// stream, a negedge monitor pops and compares each presented output.
module tb_vec_chunk_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       StartE;
    logic [4:0] VlE;
    logic       MemOpE;
    logic       MemReadyM;
    logic       FlushE;
    logic       ChunkValid;
    logic [3:0] ChunkBase;
    logic [3:0] LaneMask;
    logic       ChunkLast;
    logic       StallSeq;
    logic       DoneE;

    vec_chunk_sequencer #(.VLEN(16), .LANES(4)) dut (
        .clk(clk), .reset(reset), .StartE(StartE), .VlE(VlE), .MemOpE(MemOpE),
        .MemReadyM(MemReadyM), .FlushE(FlushE), .ChunkValid(ChunkValid),
        .ChunkBase(ChunkBase), .LaneMask(LaneMask), .ChunkLast(ChunkLast),
        .StallSeq(StallSeq), .DoneE(DoneE)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       isDone;
        logic [3:0] base;
        logic [3:0] mask;
        logic       last;
    } ev_t;

    ev_t expQ[$];
    int  checks = 0;
    int  passes = 0;
    int  cyc, stallCnt, doneCnt, doneCyc, validCnt;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic pushChunk(input int b, input int m, input int l);
        ev_t e;
        e.isDone = 1'b0; e.base = 4'(b); e.mask = 4'(m); e.last = 1'(l);
        expQ.push_back(e);
    endtask

    task automatic pushDone();
        ev_t e;
        e = '0; e.isDone = 1'b1;
        expQ.push_back(e);
    endtask

    // Monitor: every presented chunk or done pulse must match the head of the queue.
    always @(negedge clk) begin
        if (ChunkValid || DoneE) begin
            if (expQ.size() == 0) begin
                chk("unexpectedOutput", 1, 0);
            end else begin
                ev_t e;
                e = expQ.pop_front();
                if (e.isDone) begin
                    chk("doneKind", {ChunkValid, DoneE}, 2'b01);
                end else begin
                    chk("chunkKind", {ChunkValid, DoneE}, 2'b10);
                    chk("chunkBase", ChunkBase, e.base);
                    chk("laneMask", LaneMask, e.mask);
                    chk("chunkLast", ChunkLast, e.last);
                end
                $display("t=%0t cyc=%0d valid=%0b base=%0d mask=%b last=%0b done=%0b",
                         $time, cyc, ChunkValid, ChunkBase, LaneMask, ChunkLast, DoneE);
            end
        end
    end

    task automatic clearCounts();
        cyc = 0; stallCnt = 0; doneCnt = 0; doneCyc = 0; validCnt = 0;
    endtask

    // One cycle: inputs already driven; sample mid-cycle, return just after the next edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (StallSeq) stallCnt++;
        if (ChunkValid) validCnt++;
        if (DoneE) begin doneCnt++; doneCyc = cyc; end
        @(posedge clk);
        #1;
    endtask

    task automatic runToDone(input int lowStart, input int lowLen, input int maxCyc);
        while (doneCnt == 0 && cyc < maxCyc) begin
            MemReadyM = !((cyc + 1) >= lowStart && (cyc + 1) < lowStart + lowLen);
            tick();
        end
        StartE = 1'b0;
        MemReadyM = 1'b1;
        tick();
        tick();
        chk("doneOnce", doneCnt, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; StartE = 1'b0; VlE = '0; MemOpE = 1'b0; MemReadyM = 1'b1; FlushE = 1'b0;
        clearCounts();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rstValid", ChunkValid, 0);
        chk("rstBase", ChunkBase, 0);
        chk("rstMask", LaneMask, 0);
        chk("rstLast", ChunkLast, 0);
        chk("rstStall", StallSeq, 0);
        chk("rstDone", DoneE, 0);
        tick();

        // 1: VL=10, ALU op; MemReadyM held low must not matter
        clearCounts();
        pushChunk(0, 4'b1111, 0); pushChunk(4, 4'b1111, 0); pushChunk(8, 4'b0011, 1); pushDone();
        StartE = 1'b1; VlE = 5'd10; MemOpE = 1'b0;
        runToDone(1, 100, 20);
        chk("t1Stall", stallCnt, 4);
        chk("t1DoneCyc", doneCyc, 5);
        chk("t1Chunks", validCnt, 3);

        // 2: VL=16, memory op, back-pressure on the base-4 chunk for two cycles
        clearCounts();
        pushChunk(0, 4'b1111, 0);
        repeat (3) pushChunk(4, 4'b1111, 0);
        pushChunk(8, 4'b1111, 0); pushChunk(12, 4'b1111, 1); pushDone();
        StartE = 1'b1; VlE = 5'd16; MemOpE = 1'b1;
        runToDone(3, 2, 20);
        chk("t2Stall", stallCnt, 7);
        chk("t2DoneCyc", doneCyc, 8);
        chk("t2ChunkCycles", validCnt, 6);

        // 3a: VL=0 goes straight to DONE
        clearCounts();
        pushDone();
        StartE = 1'b1; VlE = 5'd0; MemOpE = 1'b0;
        runToDone(0, 0, 20);
        chk("t3aStall", stallCnt, 1);
        chk("t3aDoneCyc", doneCyc, 2);
        chk("t3aChunks", validCnt, 0);

        // 3b: VL=20 clamps to 16
        clearCounts();
        pushChunk(0, 4'b1111, 0); pushChunk(4, 4'b1111, 0);
        pushChunk(8, 4'b1111, 0); pushChunk(12, 4'b1111, 1); pushDone();
        StartE = 1'b1; VlE = 5'd20; MemOpE = 1'b1;
        runToDone(0, 0, 20);
        chk("t3bStall", stallCnt, 5);
        chk("t3bDoneCyc", doneCyc, 6);
        chk("t3bChunks", validCnt, 4);

        // 4a: flush in the second RUN cycle aborts without DoneE
        clearCounts();
        pushChunk(0, 4'b1111, 0); pushChunk(4, 4'b1111, 0);
        StartE = 1'b1; VlE = 5'd10; MemOpE = 1'b0;
        tick(); tick();
        FlushE = 1'b1;
        tick();
        FlushE = 1'b0; StartE = 1'b0;
        repeat (5) tick();
        chk("t4aDone", doneCnt, 0);
        chk("t4aChunks", validCnt, 2);
        chk("t4aStall", stallCnt, 3);

        // 4b: reset in RUN clears everything on the next cycle
        clearCounts();
        pushChunk(0, 4'b1111, 0); pushChunk(4, 4'b1111, 0);
        StartE = 1'b1; VlE = 5'd16; MemOpE = 1'b1; MemReadyM = 1'b1;
        tick(); tick();
        reset = 1'b1; StartE = 1'b0;
        tick();
        reset = 1'b0;
        chk("t4bValid", ChunkValid, 0);
        chk("t4bBase", ChunkBase, 0);
        chk("t4bMask", LaneMask, 0);
        chk("t4bLast", ChunkLast, 0);
        chk("t4bStall", StallSeq, 0);
        chk("t4bDone", DoneE, 0);
        repeat (3) tick();
        chk("t4bNoDone", doneCnt, 0);

        // 5: StartE held through DONE is ignored; next cycle starts a fresh op from base 0
        clearCounts();
        pushChunk(0, 4'b1111, 1); pushDone();
        pushChunk(0, 4'b1111, 0); pushChunk(4, 4'b1111, 1); pushDone();
        StartE = 1'b1; VlE = 5'd4; MemOpE = 1'b0;
        tick(); tick(); tick();
        chk("t5FirstDoneCyc", doneCyc, 3);
        chk("t5StallInDone", stallCnt, 2);
        clearCounts();
        VlE = 5'd8;
        runToDone(0, 0, 20);
        chk("t5Stall", stallCnt, 3);
        chk("t5DoneCyc", doneCyc, 4);
        chk("t5Chunks", validCnt, 2);

        repeat (2) tick();
        chk("queueEmpty", expQ.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
